imem_dmem_arbiter: RTL and testbench



---
 rtl/imem_dmem_arbiter.sv | 118 +++++++++++
 tb/tb_imem_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : imem_dmem_arbiter
// Purpose : Shares one single-port synchronous memory between instruction fetch
//           and data access; data wins, with a bounded-streak guard for fetch.
// Revision: 1.0 - initial release
// =============================================================================
module imem_dmem_arbiter #(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                MODE_W       = 2,
   parameter logic [MODE_W-1:0] WORD_MODE    = 2'b10,
   parameter int                READ_LATENCY = 1,
   parameter int                STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [MODE_W-1:0] d_mode,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MODE_W-1:0] mem_mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_BUSY_I   = 2'd1;
   localparam logic [1:0] S_BUSY_D   = 2'd2;
   localparam logic [2:0] LAT_INIT   = 3'(READ_LATENCY - 1);
   localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

   logic [1:0] state_q,   state_d;
   logic [2:0] lat_cnt_q, lat_cnt_d;
   logic [3:0] streak_q,  streak_d;
   logic       busy, done, can_issue, win_d, win_i;

   // A completing read frees the memory in the same cycle, so a new grant can overlap it.
   always_comb begin
      busy      = (state_q == S_BUSY_I) || (state_q == S_BUSY_D);
      done      = busy && (lat_cnt_q == 3'd0);
      can_issue = rst_n && (!busy || done);
      win_d     = can_issue && d_req && !(i_req && (streak_q == STREAK_MAX));
      win_i     = can_issue && i_req && !win_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         lat_cnt_q <= 3'd0;
         streak_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         streak_q  <= streak_d;
      end
   end

   always_comb begin
      state_d   = S_IDLE;
      lat_cnt_d = 3'd0;
      streak_d  = streak_q;
      if (win_d) begin
         if (!d_we) begin
            state_d   = S_BUSY_D;
            lat_cnt_d = LAT_INIT;
         end
         if (!i_req) begin
            streak_d = 4'd0;
         end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
         end
      end else if (win_i) begin
         state_d   = S_BUSY_I;
         lat_cnt_d = LAT_INIT;
         streak_d  = 4'd0;
      end else if (busy && !done) begin
         state_d   = state_q;
         lat_cnt_d = lat_cnt_q - 3'd1;
      end
   end

   always_comb begin
      i_gnt     = win_i;
      d_gnt     = win_d;
      mem_en    = win_i || win_d;
      mem_we    = win_d && d_we;
      mem_mode  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (win_d) begin
         mem_mode  = d_mode;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (win_i) begin
         mem_mode  = WORD_MODE;
         mem_addr  = i_addr;
      end
      i_rvalid = rst_n && done && (state_q == S_BUSY_I);
      d_rvalid = rst_n && done && (state_q == S_BUSY_D);
      i_rdata  = i_rvalid ? mem_rdata : '0;
      d_rdata  = d_rvalid ? mem_rdata : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_imem_dmem_arbiter
// Purpose : Scoreboard bench driving two arbiters (read latency 1 and 3) with
//           random requesters against a cycle-stamped transaction model.
// Revision: 1.0 - initial release
// =============================================================================
module tb_imem_dmem_arbiter;

   localparam int RL0   = 1;
   localparam int RL1   = 3;
   localparam int LIMIT = 4;

   typedef struct packed {
      int        t;
      bit        who_d;
      bit        we;
      bit [1:0]  mode;
      bit [31:0] addr;
      bit [31:0] wdata;
   } acc_t;

   typedef struct packed {
      int        t;
      bit        who_d;
      bit [31:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   fin = 1'b0;

   logic [1:0]       i_req, d_req, d_we;
   logic [1:0][1:0]  d_mode;
   logic [1:0][31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [1:0]       i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
   logic [1:0][1:0]  mem_mode;
   logic [1:0][31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   acc_t q_acc[2][$];
   rsp_t q_rsp[2][$];

   // requester state and reference model
   bit        ip[2], dp[2], dwe[2];
   bit [1:0]  dm[2];
   bit [31:0] ia[2], da[2], dw[2];
   int        free_at[2], strk[2];
   bit [31:0] mm[2][16];

   // memory macro emulation
   bit [31:0] mac[2][16];
   bit        pv[2][1:4];
   bit [31:0] pd[2][1:4];
   bit [31:0] junk[2];

   function automatic int rl_of(int k);
      return (k == 0) ? RL0 : RL1;
   endfunction

   function automatic bit [31:0] mem_init(int j);
      return 32'hDEADBEEF + 32'(j) * 32'h01010101;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom % 4)
         0:       return $urandom;
         1:       return 32'h100;
         default: return 32'($urandom_range(0, 63));
      endcase
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      imem_dmem_arbiter #(
         .READ_LATENCY((k == 0) ? RL0 : RL1),
         .STARVE_LIMIT(LIMIT)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_req    (i_req[k]),
         .i_addr   (i_addr[k]),
         .i_gnt    (i_gnt[k]),
         .i_rvalid (i_rvalid[k]),
         .i_rdata  (i_rdata[k]),
         .d_req    (d_req[k]),
         .d_we     (d_we[k]),
         .d_mode   (d_mode[k]),
         .d_addr   (d_addr[k]),
         .d_wdata  (d_wdata[k]),
         .d_gnt    (d_gnt[k]),
         .d_rvalid (d_rvalid[k]),
         .d_rdata  (d_rdata[k]),
         .mem_en   (mem_en[k]),
         .mem_we   (mem_we[k]),
         .mem_mode (mem_mode[k]),
         .mem_addr (mem_addr[k]),
         .mem_wdata(mem_wdata[k]),
         .mem_rdata(mem_rdata[k])
      );
   end

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin : p_macro
      for (int k = 0; k < 2; k++) begin
         if (cyc == 0) begin
            for (int j = 0; j < 16; j++) mac[k][j] <= mem_init(j);
         end else if (mem_en[k] && mem_we[k]) begin
            mac[k][mem_addr[k][5:2]] <= mem_wdata[k];
         end
         pv[k][1] <= mem_en[k] && !mem_we[k];
         pd[k][1] <= mac[k][mem_addr[k][5:2]];
         for (int s = 2; s <= 4; s++) begin
            pv[k][s] <= pv[k][s-1];
            pd[k][s] <= pd[k][s-1];
         end
         junk[k] <= $urandom;
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         mem_rdata[k] = pv[k][rl_of(k)] ? pd[k][rl_of(k)] : junk[k];
      end
   end

   task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d cycle=%0d actual=%0h required=%0h", name, k, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : p_monitor
      acc_t e;
      rsp_t r;
      int   t;
      t = cyc;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            chk("reset_outputs", k, {i_gnt[k], d_gnt[k], mem_en[k], mem_we[k], mem_mode[k], mem_addr[k],
                mem_wdata[k], i_rvalid[k], d_rvalid[k], i_rdata[k], d_rdata[k]}, '0);
         end else begin
            if (i_gnt[k] || d_gnt[k] || mem_en[k]) begin
               if (q_acc[k].size() == 0) begin
                  chk("unexpected_access", k, {i_gnt[k], d_gnt[k], mem_en[k]}, '0);
               end else begin
                  e = q_acc[k].pop_front();
                  chk("access", k, {t, i_gnt[k], d_gnt[k], mem_en[k], mem_we[k], mem_mode[k], mem_addr[k], mem_wdata[k]},
                      {e.t, !e.who_d, e.who_d, 1'b1, e.we, e.mode, e.addr, e.wdata});
               end
            end else begin
               chk("idle_mem", k, {mem_we[k], mem_mode[k], mem_addr[k], mem_wdata[k]}, '0);
               if (q_acc[k].size() != 0 && q_acc[k][0].t <= t) begin
                  e = q_acc[k].pop_front();
                  chk("missing_access", k, {1'b0, t}, {1'b1, e.t});
               end
            end
            if (i_rvalid[k] || d_rvalid[k]) begin
               if (q_rsp[k].size() == 0) begin
                  chk("unexpected_rvalid", k, {i_rvalid[k], d_rvalid[k]}, '0);
               end else begin
                  r = q_rsp[k].pop_front();
                  chk("response", k, {t, i_rvalid[k], d_rvalid[k], i_rdata[k], d_rdata[k]},
                      {r.t, !r.who_d, r.who_d, r.who_d ? 32'h0 : r.data, r.who_d ? r.data : 32'h0});
               end
            end else begin
               chk("idle_rdata", k, {i_rdata[k], d_rdata[k]}, '0);
               if (q_rsp[k].size() != 0 && q_rsp[k][0].t <= t) begin
                  r = q_rsp[k].pop_front();
                  chk("missing_rvalid", k, {1'b0, t}, {1'b1, r.t});
               end
            end
         end
         if (fin) chk("drained", k, {q_acc[k].size(), q_rsp[k].size()}, '0);
      end
   end

   // One cycle: update requesters, drive pins, then predict this cycle's grant.
   task automatic step(input int pi, input int pdq, input int pw, input int pdrop);
      int t;
      bit gd, gi;
      @(posedge clk);
      #1;
      t     = cyc;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (!ip[k] && ($urandom % 100) < pi) begin
            ip[k] = 1'b1;
            ia[k] = rand_addr();
         end else if (ip[k] && ($urandom % 100) < pdrop) begin
            ip[k] = 1'b0;
         end
         if (!dp[k] && ($urandom % 100) < pdq) begin
            dp[k]  = 1'b1;
            dwe[k] = ($urandom % 100) < pw;
            dm[k]  = 2'($urandom);
            da[k]  = rand_addr();
            dw[k]  = $urandom;
         end else if (dp[k] && ($urandom % 100) < pdrop) begin
            dp[k] = 1'b0;
         end
         i_req[k]   = ip[k];
         i_addr[k]  = ip[k] ? ia[k] : $urandom;
         d_req[k]   = dp[k];
         d_we[k]    = dp[k] ? dwe[k] : 1'($urandom);
         d_mode[k]  = dp[k] ? dm[k] : 2'($urandom);
         d_addr[k]  = dp[k] ? da[k] : $urandom;
         d_wdata[k] = dp[k] ? dw[k] : $urandom;
         if (t >= free_at[k]) begin
            gd = dp[k] && !(ip[k] && strk[k] == LIMIT);
            gi = ip[k] && !gd;
            if (gd) begin
               q_acc[k].push_back('{t, 1'b1, dwe[k], dm[k], da[k], dw[k]});
               if (dwe[k]) begin
                  mm[k][da[k][5:2]] = dw[k];
                  free_at[k] = t + 1;
               end else begin
                  q_rsp[k].push_back('{t + rl_of(k), 1'b1, mm[k][da[k][5:2]]});
                  free_at[k] = t + rl_of(k);
               end
               strk[k] = ip[k] ? ((strk[k] < LIMIT) ? strk[k] + 1 : strk[k]) : 0;
               dp[k] = 1'b0;
            end else if (gi) begin
               q_acc[k].push_back('{t, 1'b0, 1'b0, 2'b10, ia[k], 32'h0});
               q_rsp[k].push_back('{t + rl_of(k), 1'b0, mm[k][ia[k][5:2]]});
               free_at[k] = t + rl_of(k);
               strk[k] = 0;
               ip[k] = 1'b0;
            end
         end
      end
   endtask

   // Anything in flight is abandoned; the arbiter is free on the first cycle out of reset.
   task automatic do_reset(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         for (int k = 0; k < 2; k++) begin
            ip[k] = 1'b0;
            dp[k] = 1'b0;
            i_req[k] = 1'b0;
            d_req[k] = 1'b0;
            q_acc[k].delete();
            q_rsp[k].delete();
            strk[k] = 0;
            free_at[k] = cyc + 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) step(0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      i_req = '0; d_req = '0; d_we = '0; d_mode = '0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 16; j++) mm[k][j] = mem_init(j);
      end
      do_reset(3);

      for (int k = 0; k < 2; k++) begin ip[k] = 1'b1; ia[k] = 32'h100; end
      step(0, 0, 0, 0);
      idle(5);
      for (int k = 0; k < 2; k++) begin
         ip[k] = 1'b1; ia[k] = 32'h104;
         dp[k] = 1'b1; dwe[k] = 1'b0; dm[k] = 2'b10; da[k] = 32'h200; dw[k] = 32'h5;
      end
      step(0, 0, 0, 0);
      idle(8);
      for (int k = 0; k < 2; k++) begin
         dp[k] = 1'b1; dwe[k] = 1'b1; dm[k] = 2'b00; da[k] = 32'h3; dw[k] = 32'hAB;
      end
      step(0, 0, 0, 0);
      idle(5);

      for (int c = 0; c < 60; c++)  step(100, 100, 100, 0);
      idle(6);
      for (int c = 0; c < 400; c++) step(50, 50, 40, 5);
      for (int c = 0; c < 300; c++) step(80, 80, 30, 0);
      idle(8);

      for (int k = 0; k < 2; k++) begin ip[k] = 1'b1; ia[k] = 32'h100; end
      step(0, 0, 0, 0);
      do_reset(2);
      for (int k = 0; k < 2; k++) begin ip[k] = 1'b1; ia[k] = 32'h108; end
      step(0, 0, 0, 0);
      idle(8);

      for (int c = 0; c < 300; c++) step(60, 60, 50, 3);
      idle(10);
      fin = 1'b1;
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
